// File: rtl/shift_normalizer_pkg.sv
// shift_normalizer_pkg: shared state encoding and default widths for the normalizer / barrel shifter path
package shift_normalizer_pkg;
    localparam int NORM_WIDTH = 8;
    localparam int NORM_MAG_W = 3;
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;
endpackage

// File: rtl/shift_normalizer.sv
// shift_normalizer: iterative left-justifier returning the leading-zero count as shift_mag
module shift_normalizer
    import shift_normalizer_pkg::*;
#(
    parameter int WIDTH = NORM_WIDTH,
    parameter int MAG_W = NORM_MAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Ip,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Op,
    output logic [MAG_W-1:0] shift_mag,
    output logic             zero
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [MAG_W-1:0] cnt_q, cnt_d;
    logic             zero_q, zero_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
        end
    end
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = Ip;
                    cnt_d   = '0;
                    zero_d  = (Ip == '0);
                    state_d = (Ip[WIDTH-1] || Ip == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                // bit WIDTH-2 becomes the MSB after this shift, so stop here
                work_d  = work_q << 1;
                cnt_d   = cnt_q + MAG_W'(1);
                state_d = work_q[WIDTH-2] ? DONE : SHIFT;
            end
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Op        = work_q;
    assign shift_mag = cnt_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_shift_normalizer.sv
// tb_shift_normalizer: directed table vectors plus hand-written handshake, reset and stream sequences
module tb_shift_normalizer;
    import shift_normalizer_pkg::*;
    localparam int W  = NORM_WIDTH;
    localparam int MW = NORM_MAG_W;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, out_valid, out_ready, zero;
    logic [W-1:0]  Ip, Op;
    logic [MW-1:0] shift_mag;
    int            compared = 0;
    int            mismatched = 0;

    shift_normalizer #(.WIDTH(W), .MAG_W(MW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .Ip(Ip),
        .out_valid(out_valid), .out_ready(out_ready), .Op(Op), .shift_mag(shift_mag), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  ip;
        logic [W-1:0]  op;
        logic [MW-1:0] mag;
        logic          z;
        int            lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // accept one operand, then wait (bounded) for out_valid; no output handshake here
    task automatic do_op(input logic [W-1:0] ip, output int lat);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        in_valid = 1'b1;
        Ip = ip;
        tick();
        in_valid = 1'b0;
        Ip = $urandom_range(0, 255);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic model(input logic [W-1:0] ip, output logic [W-1:0] op, output logic [MW-1:0] mag);
        op = ip;
        mag = '0;
        if (ip != '0) begin
            while (!op[W-1]) begin
                op = op << 1;
                mag++;
            end
        end
    endtask

    initial begin
        vec_t          vecs[6];
        logic [W-1:0]  stream[6];
        logic [W-1:0]  eop;
        logic [MW-1:0] emag;
        int            lat, pi, ci, cyc;
        logic          acc, hs;

        vecs[0] = '{ip: 8'd16,  op: 8'd128, mag: 3'd3, z: 1'b0, lat: 4};
        vecs[1] = '{ip: 8'd44,  op: 8'd176, mag: 3'd2, z: 1'b0, lat: 3};
        vecs[2] = '{ip: 8'd12,  op: 8'd192, mag: 3'd4, z: 1'b0, lat: 5};
        vecs[3] = '{ip: 8'd128, op: 8'd128, mag: 3'd0, z: 1'b0, lat: 1};
        vecs[4] = '{ip: 8'd1,   op: 8'd128, mag: 3'd7, z: 1'b0, lat: 8};
        vecs[5] = '{ip: 8'd0,   op: 8'd0,   mag: 3'd0, z: 1'b1, lat: 1};
        stream = '{8'd16, 8'd4, 8'd44, 8'd6, 8'd12, 8'd10};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        Ip = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset Op", Op, 0);
        chk("reset shift_mag", shift_mag, 0);
        chk("reset zero", zero, 0);

        foreach (vecs[i]) begin
            do_op(vecs[i].ip, lat);
            chk($sformatf("vec%0d Op", i), Op, vecs[i].op);
            chk($sformatf("vec%0d shift_mag", i), shift_mag, vecs[i].mag);
            chk($sformatf("vec%0d zero", i), zero, vecs[i].z);
            chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d in_ready in DONE", i), in_ready, 0);
            tick();
            chk($sformatf("vec%0d back to IDLE", i), in_ready, 1);
            chk($sformatf("vec%0d out_valid dropped", i), out_valid, 0);
        end

        out_ready = 1'b0;
        do_op(8'd6, lat);
        for (int c = 0; c < 5; c++) begin
            chk("bp out_valid", out_valid, 1);
            chk("bp Op", Op, 192);
            chk("bp shift_mag", shift_mag, 5);
            chk("bp in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        Ip = 8'd128;
        chk("bp in_ready on handshake", in_ready, 0);
        tick();
        in_valid = 1'b0;
        chk("bp idle after handshake", in_ready, 1);
        chk("bp no accept during DONE", out_valid, 0);

        in_valid = 1'b1;
        Ip = 8'd4;
        tick();
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            in_valid = ~in_valid;
            Ip = 8'd255;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk("iso out_valid", out_valid, 1);
        chk("iso Op", Op, 128);
        chk("iso shift_mag", shift_mag, 5);
        tick();
        repeat (3) tick();
        chk("iso no second op", out_valid, 0);
        chk("iso idle", in_ready, 1);

        in_valid = 1'b1;
        Ip = 8'd2;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("midrst out_valid", out_valid, 0);
        chk("midrst Op", Op, 0);
        chk("midrst shift_mag", shift_mag, 0);
        chk("midrst zero", zero, 0);
        rst = 1'b0;
        repeat (8) tick();
        chk("midrst no pulse", out_valid, 0);
        do_op(8'd10, lat);
        chk("postrst Op", Op, 160);
        chk("postrst shift_mag", shift_mag, 4);
        tick();

        pi = 0;
        ci = 0;
        cyc = 0;
        while (ci < 6 && cyc < 1000) begin
            in_valid = (pi < 6);
            Ip = (pi < 6) ? stream[pi] : '0;
            out_ready = 1'($urandom_range(0, 1));
            acc = in_valid && in_ready;
            hs = out_valid && out_ready;
            if (hs) begin
                model(stream[ci], eop, emag);
                chk($sformatf("stream%0d Op", ci), Op, eop);
                chk($sformatf("stream%0d shift_mag", ci), shift_mag, emag);
                chk($sformatf("stream%0d restore", ci), Op >> shift_mag, stream[ci]);
                ci++;
            end
            tick();
            if (acc) pi++;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream results received", ci, 6);
        chk("stream operands accepted", pi, 6);
        repeat (3) tick();
        chk("stream no duplicate", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
